// File: rtl/seq_lut_loader.sv
// Load controller for the panel sequencer LUT: holds the sequencer in RST, streams host
// words through its auto-incrementing write port, optionally reads back and checksums.
module seq_lut_loader #(
    parameter int DATA_W      = 29,
    parameter int DEPTH       = 256,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [8:0]        num_entries_i,
    input  logic              verify_en_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o,
    output logic [31:0]       checksum_o,
    output logic              seq_cfg_reset_o,
    output logic              seq_addr_clr_o,
    output logic              seq_lut_wen_o,
    output logic [DATA_W-1:0] seq_lut_wdata_o,
    output logic              seq_lut_rden_o,
    input  logic [DATA_W-1:0] seq_lut_rdata_i
);
    localparam int CNT_W   = 9;
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR_W, S_WRITE, S_WDRAIN, S_CLR_R,
        S_VERIFY, S_CHECK, S_RELEASE, S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                verify_q, verify_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [31:0]         wr_sum_q, wr_sum_d, rd_sum_q, rd_sum_d;
    logic [31:0]         checksum_q, checksum_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                error_q, error_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                cfg_reset_q, cfg_reset_d;
    logic                accept;

    assign accept = (state_q == S_WRITE) && (wr_cnt_q != n_q) && wr_valid_i;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        verify_d    = verify_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        stall_d     = stall_q;
        wr_sum_d    = wr_sum_q;
        rd_sum_d    = rd_sum_q;
        checksum_d  = checksum_q;
        wen_d       = accept;
        wdata_d     = accept ? wr_data_i : wdata_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        cfg_reset_d = cfg_reset_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d         = num_entries_i;
                    verify_d    = verify_en_i;
                    error_d     = 1'b0;
                    err_code_d  = 2'd0;
                    cfg_reset_d = 1'b1;
                    wr_sum_d    = '0;
                    rd_sum_d    = '0;
                    if (num_entries_i == '0 || num_entries_i > DEPTH_C) begin
                        state_d    = S_FAIL;
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                    end else begin
                        state_d = S_CLR_W;
                    end
                end
            end
            S_CLR_W: begin
                wr_sum_d = '0;
                rd_sum_d = '0;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
                stall_d  = '0;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                // An accept always clears the stall count, so it beats a same-cycle timeout.
                if (accept) begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    wr_sum_d = wr_sum_q + 32'(wr_data_i);
                    stall_d  = '0;
                    if (wr_cnt_q == n_q - CNT_W'(1)) begin
                        state_d = S_WDRAIN;
                    end
                end else if (stall_q == STALL_LAST) begin
                    state_d    = S_FAIL;
                    error_d    = 1'b1;
                    err_code_d = 2'd2;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            S_WDRAIN: begin
                if (verify_q) begin
                    state_d = S_CLR_R;
                end else begin
                    state_d     = S_RELEASE;
                    cfg_reset_d = 1'b0;
                end
            end
            S_CLR_R: begin
                rd_cnt_d = '0;
                rd_sum_d = '0;
                state_d  = S_VERIFY;
            end
            S_VERIFY: begin
                rd_sum_d = rd_sum_q + 32'(seq_lut_rdata_i);
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_q == n_q - CNT_W'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rd_sum_q == wr_sum_q) begin
                    state_d     = S_RELEASE;
                    cfg_reset_d = 1'b0;
                end else begin
                    state_d    = S_FAIL;
                    error_d    = 1'b1;
                    err_code_d = 2'd3;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            S_FAIL:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (state_d == S_RELEASE || state_d == S_FAIL) begin
            checksum_d = wr_sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            verify_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            stall_q     <= '0;
            wr_sum_q    <= '0;
            rd_sum_q    <= '0;
            checksum_q  <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
            cfg_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            verify_q    <= verify_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            stall_q     <= stall_d;
            wr_sum_q    <= wr_sum_d;
            rd_sum_q    <= rd_sum_d;
            checksum_q  <= checksum_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            cfg_reset_q <= cfg_reset_d;
        end
    end

    assign wr_ready_o      = (state_q == S_WRITE) && (wr_cnt_q != n_q);
    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = (state_q == S_RELEASE) || (state_q == S_FAIL);
    assign error_o         = error_q;
    assign err_code_o      = err_code_q;
    assign checksum_o      = checksum_q;
    assign seq_cfg_reset_o = cfg_reset_q;
    assign seq_addr_clr_o  = (state_q == S_CLR_W) || (state_q == S_CLR_R);
    assign seq_lut_wen_o   = wen_q;
    assign seq_lut_wdata_o = wdata_q;
    assign seq_lut_rden_o  = (state_q == S_VERIFY);

endmodule
